// File: rtl/mem_io_bridge_if.sv
// Bundle of the control-unit request/response signals and the SRAM pins seen by mem_io_bridge.
// The bridge uses the slave modport; the driver of requests and the SRAM model use master.
interface mem_io_bridge_if;
  logic        MEM_RD;
  logic        MEM_WE;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] Switches;
  logic [15:0] Data_from_SRAM;
  logic [15:0] MDR_In;
  logic        MEM_R;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic        CE_N;
  logic        OE_N;
  logic        WE_N;
  logic [15:0] HEX_Data;

  modport master (
    output MEM_RD, MEM_WE, MAR, MDR, Switches, Data_from_SRAM,
    input  MDR_In, MEM_R, ADDR, Data_to_SRAM, CE_N, OE_N, WE_N, HEX_Data
  );

  modport slave (
    input  MEM_RD, MEM_WE, MAR, MDR, Switches, Data_from_SRAM,
    output MDR_In, MEM_R, ADDR, Data_to_SRAM, CE_N, OE_N, WE_N, HEX_Data
  );
endinterface

// File: rtl/mem_io_bridge.sv
// LC-3 memory/I-O bridge: runs one SRAM read or write per request with WAIT_CYCLES extra strobe cycles.
// Define IO_MAP_EN to map address 16'hFFFF to Switches (read) and HEX_Data (write).
module mem_io_bridge #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic           Clk,
  input  logic           Reset,
  mem_io_bridge_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        armed_q;
  logic        mem_r_q;
  logic        ce_n_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic [15:0] mdr_in_q;
  logic [19:0] addr_q;
  logic [15:0] data_to_sram_q;

  logic        start_io;
  logic [15:0] rd_data;

`ifdef IO_MAP_EN
  logic        io_q;
  logic [15:0] hex_q;

  assign start_io     = (bus.MAR == 16'hFFFF);
  assign rd_data      = io_q ? bus.Switches : bus.Data_from_SRAM;
  assign bus.HEX_Data = hex_q;
`else
  assign start_io     = 1'b0;
  assign rd_data      = bus.Data_from_SRAM;
  assign bus.HEX_Data = 16'h0000;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      armed_q        <= 1'b1;
      mem_r_q        <= 1'b0;
      ce_n_q         <= 1'b1;
      oe_n_q         <= 1'b1;
      we_n_q         <= 1'b1;
      mdr_in_q       <= 16'h0000;
      addr_q         <= 20'h00000;
      data_to_sram_q <= 16'h0000;
`ifdef IO_MAP_EN
      io_q           <= 1'b0;
      hex_q          <= 16'h0000;
`endif
    end else begin
      // NOTE: non-blocking default makes MEM_R a one-cycle pulse; only the DONE transitions override it.
      mem_r_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.MEM_RD && !bus.MEM_WE) armed_q <= 1'b1;
          if (armed_q && bus.MEM_WE) begin
            addr_q         <= {4'h0, bus.MAR};
            data_to_sram_q <= bus.MDR;
            cnt_q          <= WAIT_LD;
            ce_n_q         <= start_io;
            we_n_q         <= start_io;
`ifdef IO_MAP_EN
            io_q           <= start_io;
`endif
            state_q        <= WR_WAIT;
          end else if (armed_q && bus.MEM_RD) begin
            addr_q  <= {4'h0, bus.MAR};
            cnt_q   <= WAIT_LD;
            ce_n_q  <= start_io;
            oe_n_q  <= start_io;
`ifdef IO_MAP_EN
            io_q    <= start_io;
`endif
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_q == 4'd0) begin
            mdr_in_q <= rd_data;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            mem_r_q  <= 1'b1;
            state_q  <= RD_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WR_WAIT: begin
          if (cnt_q == 4'd0) begin
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            mem_r_q <= 1'b1;
`ifdef IO_MAP_EN
            if (io_q) hex_q <= data_to_sram_q;
`endif
            state_q <= WR_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RD_DONE, WR_DONE: begin
          // Disarm so a request still held after MEM_R cannot start a second access.
          armed_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.MDR_In       = mdr_in_q;
  assign bus.MEM_R        = mem_r_q;
  assign bus.ADDR         = addr_q;
  assign bus.Data_to_SRAM = data_to_sram_q;
  assign bus.CE_N         = ce_n_q;
  assign bus.OE_N         = oe_n_q;
  assign bus.WE_N         = we_n_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: vector table of accesses with a scoreboard,
// plus sequences for a held request and reset mid-access.
module tb_mem_io_bridge;

  localparam int W = 2;
`ifdef IO_MAP_EN
  localparam bit IO = 1'b1;
`else
  localparam bit IO = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mem_io_bridge_if bus ();

  mem_io_bridge #(.WAIT_CYCLES(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] sram;
    logic [15:0] exp_mdr_in;
    logic [15:0] exp_d2s;
    logic [15:0] exp_hex;
    int          exp_ce;
    int          exp_oe;
    int          exp_we;
  } vec_t;

  typedef struct {
    logic [15:0] mdr_in;
    logic [19:0] addr;
    logic [15:0] d2s;
    logic [15:0] hex;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request at a falling edge, then watch the strobes until MEM_R.
  task automatic run_access(input string tag, input vec_t v, input bit hold);
    int   ce = 0;
    int   oe = 0;
    int   we = 0;
    int   lat = 0;
    bit   done = 1'b0;
    exp_t e;
    @(negedge Clk);
    bus.MAR            = v.mar;
    bus.MDR            = v.mdr;
    bus.Data_from_SRAM = v.sram;
    bus.MEM_RD         = v.rd;
    bus.MEM_WE         = v.wr;
    sb.push_back('{v.exp_mdr_in, {4'h0, v.mar}, v.exp_d2s, v.exp_hex});
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge Clk);
      lat++;
      if (!bus.CE_N) ce++;
      if (!bus.OE_N) oe++;
      if (!bus.WE_N) we++;
      if (bus.MEM_R) done = 1'b1;
      if (i == 0) begin
        bus.MAR = ~v.mar;
        bus.MDR = ~v.mdr;
      end
    end
    check({tag, " mem_r_seen"}, 32'(done), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    if (done) begin
      check({tag, " latency"}, lat, W + 2);
      check({tag, " ce_cycles"}, ce, v.exp_ce);
      check({tag, " oe_cycles"}, oe, v.exp_oe);
      check({tag, " we_cycles"}, we, v.exp_we);
      check({tag, " strobes_done"}, {bus.CE_N, bus.OE_N, bus.WE_N}, 3'b111);
      check({tag, " mdr_in"}, bus.MDR_In, e.mdr_in);
      check({tag, " addr"}, bus.ADDR, e.addr);
      check({tag, " data_to_sram"}, bus.Data_to_SRAM, e.d2s);
      check({tag, " hex"}, bus.HEX_Data, e.hex);
    end
    if (!hold) begin
      bus.MEM_RD = 1'b0;
      bus.MEM_WE = 1'b0;
      @(negedge Clk);
      check({tag, " mem_r_one_cycle"}, bus.MEM_R, 1'b0);
    end
  endtask

  initial begin
    vec_t hv;
    int   strobe_cnt;
    int   mem_r_cnt;

    vecs[0] = '{1, 0, 16'h0030, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000, W+1, W+1, 0};
    vecs[1] = '{0, 1, 16'h0031, 16'h1234, 16'h0000, 16'hBEEF, 16'h1234, 16'h0000, W+1, 0, W+1};
    vecs[2] = '{1, 0, 16'hFFFE, 16'h0000, 16'h0F0F, 16'h0F0F, 16'h1234, 16'h0000, W+1, W+1, 0};
    vecs[3] = '{1, 1, 16'h0040, 16'hA55A, 16'h7777, 16'h0F0F, 16'hA55A, 16'h0000, W+1, 0, W+1};
    vecs[4] = '{1, 0, 16'hFFFF, 16'h0000, 16'h5A5A, IO ? 16'h00A5 : 16'h5A5A, 16'hA55A, 16'h0000,
                IO ? 0 : W+1, IO ? 0 : W+1, 0};
    vecs[5] = '{0, 1, 16'hFFFF, 16'h4C33, 16'h0000, IO ? 16'h00A5 : 16'h5A5A, 16'h4C33,
                IO ? 16'h4C33 : 16'h0000, IO ? 0 : W+1, 0, IO ? 0 : W+1};
    vecs[6] = '{1, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h4C33,
                IO ? 16'h4C33 : 16'h0000, W+1, W+1, 0};

    Reset              = 1'b0;
    bus.MEM_RD         = 1'b0;
    bus.MEM_WE         = 1'b0;
    bus.MAR            = 16'h0000;
    bus.MDR            = 16'h0000;
    bus.Switches       = 16'h00A5;
    bus.Data_from_SRAM = 16'h0000;

    repeat (2) @(negedge Clk);
    check("reset strobes", {bus.CE_N, bus.OE_N, bus.WE_N}, 3'b111);
    check("reset mem_r", bus.MEM_R, 1'b0);
    check("reset mdr_in", bus.MDR_In, 16'h0000);
    check("reset addr", bus.ADDR, 20'h00000);
    check("reset data_to_sram", bus.Data_to_SRAM, 16'h0000);
    check("reset hex", bus.HEX_Data, 16'h0000);
    Reset = 1'b1;

    for (int i = 0; i < 7; i++) run_access($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Request held for 10 cycles past MEM_R must not start a second access.
    hv = '{1, 0, 16'h0050, 16'h0000, 16'h1111, 16'h1111, 16'h4C33,
           IO ? 16'h4C33 : 16'h0000, W+1, W+1, 0};
    run_access("hold", hv, 1'b1);
    strobe_cnt = 0;
    mem_r_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (!bus.CE_N || !bus.OE_N || !bus.WE_N) strobe_cnt++;
      if (bus.MEM_R) mem_r_cnt++;
    end
    check("hold no_strobes", strobe_cnt, 0);
    check("hold no_mem_r", mem_r_cnt, 0);
    check("hold mdr_in", bus.MDR_In, 16'h1111);
    bus.MEM_RD = 1'b0;
    hv = '{1, 0, 16'h0051, 16'h0000, 16'h2222, 16'h2222, 16'h4C33,
           IO ? 16'h4C33 : 16'h0000, W+1, W+1, 0};
    run_access("rearm", hv, 1'b0);

    // Reset in the second RD_WAIT cycle aborts the read.
    @(negedge Clk);
    bus.MAR            = 16'h0060;
    bus.Data_from_SRAM = 16'h3333;
    bus.MEM_RD         = 1'b1;
    repeat (2) @(negedge Clk);
    check("abort strobes_active", {bus.CE_N, bus.OE_N}, 2'b00);
    Reset      = 1'b0;
    bus.MEM_RD = 1'b0;
    #1;
    check("abort strobes", {bus.CE_N, bus.OE_N, bus.WE_N}, 3'b111);
    check("abort mem_r", bus.MEM_R, 1'b0);
    check("abort mdr_in", bus.MDR_In, 16'h0000);
    check("abort hex", bus.HEX_Data, 16'h0000);
    mem_r_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (bus.MEM_R) mem_r_cnt++;
    end
    check("abort no_mem_r", mem_r_cnt, 0);
    Reset = 1'b1;

    hv = '{1, 0, 16'h0070, 16'h0000, 16'hCAFE, 16'hCAFE, 16'h0000, 16'h0000, W+1, W+1, 0};
    run_access("post_reset", hv, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
